avalon_crypto_regfile: RTL and testbench

//  Parametrised Avalon-MM slave register file fronting a block-cipher core (AES or similar).
//  It holds the key and input block, and issues a one-cycle start pulse in encrypt or decrypt mode.
//  It captures the result on the core's done pulse and keeps busy/done/error status, a cycle counter and an IRQ.

---
 rtl/avalon_crypto_regfile.sv | 208 ++++++++++++++++++++
 tb/tb_avalon_crypto_regfile.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_crypto_regfile.sv
// Avalon-MM register file in front of a block-cipher core.
// Holds key and input block, launches the core with a one-cycle start pulse,
// captures the result on the core's done pulse and keeps sticky status,
// a busy-cycle counter and an interrupt line.
//
// Bus handshake: there is no waitrequest. A read or write is accepted in the
// cycle it is presented with AVL_CS high; write data lands on the next posedge
// and read data is returned combinationally in the same cycle.
module avalon_crypto_regfile #(
    parameter int DATA_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  AVL_READ,
    input  logic                  AVL_WRITE,
    input  logic                  AVL_CS,
    input  logic [DATA_W/8-1:0]   AVL_BYTE_EN,
    input  logic [ADDR_W-1:0]     AVL_ADDR,
    input  logic [DATA_W-1:0]     AVL_WRITEDATA,
    output logic [DATA_W-1:0]     AVL_READDATA,
    output logic                  CORE_START,
    output logic                  CORE_MODE,
    output logic [BLOCK_W-1:0]    CORE_KEY,
    output logic [BLOCK_W-1:0]    CORE_DIN,
    input  logic [BLOCK_W-1:0]    CORE_DOUT,
    input  logic                  CORE_DONE,
    output logic                  IRQ,
    output logic [DATA_W-1:0]     EXPORT_DATA,
    output logic [1:0]            DBG_STATE
);

    localparam int N        = BLOCK_W / DATA_W;
    localparam int NB       = DATA_W / 8;
    localparam int A_CTRL   = 3 * N;
    localparam int A_STATUS = 3 * N + 1;
    localparam int A_CYCLES = 3 * N + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   key_q  [N];
    logic [DATA_W-1:0]   key_d  [N];
    logic [DATA_W-1:0]   din_q  [N];
    logic [DATA_W-1:0]   din_d  [N];
    logic [DATA_W-1:0]   dout_q [N];
    logic [DATA_W-1:0]   dout_d [N];
    logic                mode_q, mode_d;
    logic                irq_en_q, irq_en_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                tmo_q, tmo_d;
    logic [DATA_W-1:0]   cycles_q, cycles_d;

    logic                wr_en;
    logic                busy;
    logic                w1c;
    logic                done_set, err_set, tmo_set;
    int                  addr_idx;

    assign wr_en    = AVL_WRITE & AVL_CS;
    assign busy     = (state_q != S_IDLE);
    assign addr_idx = int'(AVL_ADDR);
    assign w1c      = wr_en && (addr_idx == A_STATUS) && AVL_BYTE_EN[0];

    // Replace only the byte lanes whose enable is set.
    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [NB-1:0]     be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

    // Next-state: register writes, busy protection, FSM and sticky status.
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        din_d    = din_q;
        dout_d   = dout_q;
        mode_d   = mode_q;
        irq_en_d = irq_en_q;
        cycles_d = cycles_q;
        done_set = 1'b0;
        err_set  = 1'b0;
        tmo_set  = 1'b0;

        if (wr_en) begin
            if (busy) begin
                // Configuration is frozen while the core is working.
                if (addr_idx < 2 * N || addr_idx == A_CTRL) err_set = 1'b1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (addr_idx == i)     key_d[i] = merge_bytes(key_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
                    if (addr_idx == N + i) din_d[i] = merge_bytes(din_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
                end
                if (addr_idx == A_CTRL && AVL_BYTE_EN[0]) begin
                    mode_d   = AVL_WRITEDATA[1];
                    irq_en_d = AVL_WRITEDATA[2];
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (wr_en && addr_idx == A_CTRL && AVL_BYTE_EN[0] && AVL_WRITEDATA[0]) begin
                    state_d  = S_START;
                    cycles_d = '0;
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cycles_q != '1) cycles_d = cycles_q + DATA_W'(1);
                if (CORE_DONE) begin
                    for (int i = 0; i < N; i++) begin
                        dout_d[i] = CORE_DOUT[BLOCK_W-1-i*DATA_W -: DATA_W];
                    end
                    done_set = 1'b1;
                    state_d  = S_IDLE;
                end else if (TIMEOUT != 0 && cycles_q == DATA_W'(TIMEOUT - 1)) begin
                    tmo_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Sticky bits: a set in the same cycle as a clear wins.
        done_d = (done_q & ~(w1c & AVL_WRITEDATA[1])) | done_set;
        err_d  = (err_q  & ~(w1c & AVL_WRITEDATA[2])) | err_set;
        tmo_d  = (tmo_q  & ~(w1c & AVL_WRITEDATA[3])) | tmo_set;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < N; i++) begin
                key_q[i]  <= '0;
                din_q[i]  <= '0;
                dout_q[i] <= '0;
            end
            mode_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            din_q    <= din_d;
            dout_q   <= dout_d;
            mode_q   <= mode_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            cycles_q <= cycles_d;
        end
    end

    // Combinational read mux; unmapped or idle bus returns zero.
    always_comb begin
        AVL_READDATA = '0;
        if (AVL_READ && AVL_CS) begin
            for (int i = 0; i < N; i++) begin
                if (addr_idx == i)         AVL_READDATA = key_q[i];
                if (addr_idx == N + i)     AVL_READDATA = din_q[i];
                if (addr_idx == 2 * N + i) AVL_READDATA = dout_q[i];
            end
            if (addr_idx == A_CTRL) begin
                AVL_READDATA[1] = mode_q;
                AVL_READDATA[2] = irq_en_q;
            end
            if (addr_idx == A_STATUS) AVL_READDATA[3:0] = {tmo_q, err_q, done_q, busy};
            if (addr_idx == A_CYCLES) AVL_READDATA = cycles_q;
        end
    end

    // Pack key and input words for the core, word 0 in the most significant slot.
    always_comb begin
        CORE_KEY = '0;
        CORE_DIN = '0;
        for (int i = 0; i < N; i++) begin
            CORE_KEY[BLOCK_W-1-i*DATA_W -: DATA_W] = key_q[i];
            CORE_DIN[BLOCK_W-1-i*DATA_W -: DATA_W] = din_q[i];
        end
    end

    assign CORE_START  = (state_q == S_START);
    assign CORE_MODE   = mode_q;
    assign IRQ         = done_q & irq_en_q;
    assign EXPORT_DATA = {key_q[0][DATA_W-1 -: DATA_W/2], key_q[N-1][DATA_W/2-1:0]};
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_avalon_crypto_regfile.sv
// Bench for avalon_crypto_regfile: a no-timeout instance checked every cycle
// against a behavioural model, plus a TIMEOUT=8 instance for abort and reset cases.
module tb_avalon_crypto_regfile;

    localparam int DW     = 32;
    localparam int BW     = 128;
    localparam int AW     = 4;
    localparam int N      = 4;
    localparam int A_CTRL = 12;
    localparam int A_STAT = 13;
    localparam int A_CYC  = 14;

    // ---------------- clock / reset ----------------
    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bus and core signals ----------------
    logic          AVL_READ      = 1'b0;
    logic          AVL_WRITE     = 1'b0;
    logic          AVL_CS        = 1'b0;
    logic [3:0]    AVL_BYTE_EN   = 4'h0;
    logic [AW-1:0] AVL_ADDR      = '0;
    logic [DW-1:0] AVL_WRITEDATA = '0;
    logic          sel           = 1'b0;
    logic          cs0, cs1;
    assign cs0 = AVL_CS & ~sel;
    assign cs1 = AVL_CS & sel;

    logic [BW-1:0] core_dout0 = '0, core_dout1 = '0;
    logic          core_done0 = 1'b0, core_done1 = 1'b0;
    logic [DW-1:0] rd0, rd1, exp0, exp1;
    logic          start0, start1, mode0, mode1, irq0, irq1;
    logic [BW-1:0] key0, key1, din0, din1;
    logic [1:0]    dbg0, dbg1;

    avalon_crypto_regfile #(.DATA_W(DW), .BLOCK_W(BW), .ADDR_W(AW), .TIMEOUT(0)) dut (
        .CLK(CLK), .RESET(RESET), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(cs0),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(rd0), .CORE_START(start0), .CORE_MODE(mode0), .CORE_KEY(key0),
        .CORE_DIN(din0), .CORE_DOUT(core_dout0), .CORE_DONE(core_done0), .IRQ(irq0),
        .EXPORT_DATA(exp0), .DBG_STATE(dbg0)
    );

    avalon_crypto_regfile #(.DATA_W(DW), .BLOCK_W(BW), .ADDR_W(AW), .TIMEOUT(8)) dut_tmo (
        .CLK(CLK), .RESET(RESET), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(cs1),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(rd1), .CORE_START(start1), .CORE_MODE(mode1), .CORE_KEY(key1),
        .CORE_DIN(din1), .CORE_DOUT(core_dout1), .CORE_DONE(core_done1), .IRQ(irq1),
        .EXPORT_DATA(exp1), .DBG_STATE(dbg1)
    );

    // ---------------- scoreboard ----------------
    int   tests_run = 0;
    int   fails     = 0;
    logic chk_en    = 1'b0;
    int   start_cnt = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model of the no-timeout instance ----------------
    logic [DW-1:0] m_key [N];
    logic [DW-1:0] m_din [N];
    logic [DW-1:0] m_dout[N];
    logic          m_mode, m_irq_en, m_busy, m_start, m_done, m_err, m_tmo;
    logic [DW-1:0] m_cyc;

    function automatic logic [DW-1:0] lanes(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                            input logic [3:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] m_read(input int a);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (a == i)         r = m_key[i];
            if (a == N + i)     r = m_din[i];
            if (a == 2 * N + i) r = m_dout[i];
        end
        if (a == A_CTRL) r = {29'd0, m_irq_en, m_mode, 1'b0};
        if (a == A_STAT) r = {28'd0, m_tmo, m_err, m_done, m_busy};
        if (a == A_CYC)  r = m_cyc;
        return r;
    endfunction

    task automatic model_step();
        logic wr, running, done_evt, accept;
        int   a;
        if (!RESET) begin
            for (int i = 0; i < N; i++) begin
                m_key[i] = '0; m_din[i] = '0; m_dout[i] = '0;
            end
            {m_mode, m_irq_en, m_busy, m_start, m_done, m_err, m_tmo} = '0;
            m_cyc = '0;
        end else begin
            wr       = AVL_WRITE && cs0;
            a        = int'(AVL_ADDR);
            running  = m_busy && !m_start;
            done_evt = running && core_done0;
            accept   = wr && !m_busy && a == A_CTRL && AVL_BYTE_EN[0] && AVL_WRITEDATA[0];
            if (wr && !m_busy) begin
                for (int i = 0; i < N; i++) begin
                    if (a == i)     m_key[i] = lanes(m_key[i], AVL_WRITEDATA, AVL_BYTE_EN);
                    if (a == N + i) m_din[i] = lanes(m_din[i], AVL_WRITEDATA, AVL_BYTE_EN);
                end
                if (a == A_CTRL && AVL_BYTE_EN[0]) begin
                    m_mode   = AVL_WRITEDATA[1];
                    m_irq_en = AVL_WRITEDATA[2];
                end
            end
            if (wr && a == A_STAT && AVL_BYTE_EN[0]) begin
                if (AVL_WRITEDATA[1]) m_done = 1'b0;
                if (AVL_WRITEDATA[2]) m_err  = 1'b0;
                if (AVL_WRITEDATA[3]) m_tmo  = 1'b0;
            end
            if (wr && m_busy && (a < 2 * N || a == A_CTRL)) m_err = 1'b1;
            if (running && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
            if (done_evt) begin
                for (int i = 0; i < N; i++) m_dout[i] = core_dout0[BW-1-32*i -: 32];
                m_done = 1'b1;
                m_busy = 1'b0;
            end
            if (accept) begin
                m_busy = 1'b1;
                m_cyc  = '0;
            end
            m_start = accept;
        end
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    // Compare process: every cycle, away from the active edge.
    initial forever begin
        @(negedge CLK);
        if (start0) start_cnt++;
        if (chk_en) begin
            check("readdata", rd0, (AVL_READ && cs0) ? m_read(int'(AVL_ADDR)) : 32'd0);
            check("core_start", start0, m_start);
            check("core_mode", mode0, m_mode);
            check("core_key", key0, {m_key[0], m_key[1], m_key[2], m_key[3]});
            check("core_din", din0, {m_din[0], m_din[1], m_din[2], m_din[3]});
            check("irq", irq0, m_done & m_irq_en);
            check("export", exp0, {m_key[0][31:16], m_key[3][15:0]});
        end
    end

    // ---------------- driver tasks (entered just after a posedge) ----------------
    task automatic bus_idle();
        AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_CS = 1'b0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [3:0] be);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_READ = 1'b0;
        AVL_ADDR = AW'(a); AVL_WRITEDATA = d; AVL_BYTE_EN = be;
        @(posedge CLK); #1;
        bus_idle();
    endtask

    task automatic rd(input int a, output logic [DW-1:0] d);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_WRITE = 1'b0; AVL_ADDR = AW'(a);
        @(negedge CLK);
        d = sel ? rd1 : rd0;
        @(posedge CLK); #1;
        bus_idle();
    endtask

    task automatic rd_check(input string name, input int a, input logic [DW-1:0] exp);
        logic [DW-1:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // ---------------- directed and random sequence ----------------
    int r;
    int sc;
    initial begin
        // reset
        bus_idle();
        idle_cycles(2);
        RESET  = 1'b1;
        chk_en = 1'b1;

        // reset state
        for (int a = 0; a < 16; a++) rd_check($sformatf("reset_rd%0d", a), a, 32'd0);
        @(negedge CLK);
        check("reset_core_start", start0, 1'b0);
        check("reset_irq", irq0, 1'b0);
        check("reset_export", exp0, 32'd0);
        idle_cycles(1);

        // decrypt run with 11-cycle core latency
        wr(0, 32'h00010203, 4'hF); wr(1, 32'h04050607, 4'hF);
        wr(2, 32'h08090A0B, 4'hF); wr(3, 32'h0C0D0E0F, 4'hF);
        wr(4, 32'hDAEC3055, 4'hF); wr(5, 32'hDF058E1C, 4'hF);
        wr(6, 32'h39E814EA, 4'hF); wr(7, 32'h76F6747E, 4'hF);
        sc = start_cnt;
        wr(A_CTRL, 32'h7, 4'hF);
        idle_cycles(11);
        core_dout0 = {4{32'hAAAAAAAA}};
        core_done0 = 1'b1;
        idle_cycles(1);
        core_done0 = 1'b0;
        check("run_start_pulses", 32'(start_cnt - sc), 32'd1);
        check("run_mode", mode0, 1'b1);
        for (int i = 0; i < N; i++) rd_check($sformatf("run_dout%0d", i), 8 + i, 32'hAAAAAAAA);
        rd_check("run_status", A_STAT, 32'h2);
        check("run_irq", irq0, 1'b1);
        rd_check("run_cycles", A_CYC, 32'd11);
        check("run_key", key0, 128'h000102030405060708090A0B0C0D0E0F);
        check("run_export", exp0, 32'h00010E0F);

        // byte enables
        wr(1, 32'h11223344, 4'hF);
        wr(1, 32'hFFFFFFFF, 4'b0101);
        rd_check("byte_en", 1, 32'h11FF33FF);

        // busy protection
        sc = start_cnt;
        wr(A_CTRL, 32'h1, 4'hF);
        idle_cycles(2);
        wr(4, 32'h12345678, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        rd_check("busy_status", A_STAT, 32'h7);
        core_dout0 = {4{32'h55555555}};
        core_done0 = 1'b1;
        idle_cycles(1);
        core_done0 = 1'b0;
        check("busy_start_pulses", 32'(start_cnt - sc), 32'd1);
        rd_check("busy_din0", 4, 32'hDAEC3055);
        wr(A_STAT, 32'h4, 4'hF);
        rd_check("err_w1c", A_STAT, 32'h2);

        // set-wins collision and spurious done
        wr(A_STAT, 32'h2, 4'hF);
        rd_check("done_w1c", A_STAT, 32'h0);
        wr(A_CTRL, 32'h1, 4'hF);
        idle_cycles(3);
        core_dout0 = {4{32'h99999999}};
        core_done0 = 1'b1;
        wr(A_STAT, 32'h2, 4'hF);
        core_done0 = 1'b0;
        rd_check("collision_done", A_STAT, 32'h2);
        wr(A_STAT, 32'h2, 4'hF);
        rd_check("collision_clear", A_STAT, 32'h0);
        core_dout0 = {4{32'h12345678}};
        core_done0 = 1'b1;
        idle_cycles(1);
        core_done0 = 1'b0;
        rd_check("spurious_dout", 8, 32'h99999999);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            r             = $urandom_range(0, 9);
            core_done0    = ($urandom_range(0, 5) == 0);
            core_dout0    = {$urandom, $urandom, $urandom, $urandom};
            AVL_CS        = ($urandom_range(0, 7) != 0);
            AVL_ADDR      = AW'($urandom_range(0, 15));
            AVL_BYTE_EN   = 4'($urandom_range(0, 15));
            AVL_WRITEDATA = $urandom;
            AVL_READ      = 1'b0;
            AVL_WRITE     = 1'b0;
            if (r < 4) AVL_READ = 1'b1;
            else if (r < 7) AVL_WRITE = 1'b1;
            else if (r == 7) begin
                AVL_WRITE = 1'b1; AVL_ADDR = AW'(A_CTRL); AVL_WRITEDATA[0] = 1'b1;
            end else if (r == 8) begin
                AVL_WRITE = 1'b1; AVL_ADDR = AW'(A_STAT);
            end
            idle_cycles(1);
        end
        bus_idle();
        core_done0 = 1'b0;
        idle_cycles(2);

        // timeout instance: core never answers
        sel = 1'b1;
        wr(A_CTRL, 32'h1, 4'hF);
        idle_cycles(8);
        rd_check("tmo_still_busy", A_STAT, 32'h1);
        rd_check("tmo_abort", A_STAT, 32'h8);
        rd_check("tmo_cycles", A_CYC, 32'd8);

        // reset in the middle of a run, then a stale done
        wr(A_CTRL, 32'h1, 4'hF);
        idle_cycles(3);
        RESET = 1'b0;
        idle_cycles(1);
        RESET = 1'b1;
        rd_check("midreset_status", A_STAT, 32'h0);
        core_dout1 = {4{32'hDEADBEEF}};
        core_done1 = 1'b1;
        idle_cycles(1);
        core_done1 = 1'b0;
        rd_check("midreset_dout", 8, 32'h0);
        rd_check("midreset_status2", A_STAT, 32'h0);
        sel = 1'b0;
        idle_cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
